uart_mmio: RTL and testbench
============================

# uart_mmio

Memory-mapped UART controller between the CPU's simple bus and the byte-level UART transmitter/receiver pair. It buffers outgoing bytes in a TX FIFO and feeds the transmitter through its start/busy handshake. It drains the receiver's sticky data-ready flag into an RX FIFO. It exposes a two-register DATA/STATUS interface to software.

## Interface
Parameters:
- TX_DEPTH, 16, TX FIFO entries; must be a power of 2 and at least 2.
- RX_DEPTH, 16, RX FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  system clock; the block uses this single clock only.
- rst  in  1  reset, synchronous and active-high.
- bus_en  in  1  bus access request, one cycle per access.
- bus_we  in  1  1 = write, 0 = read.
- bus_addr  in  1  0 = DATA, 1 = STATUS.
- bus_wdata  in  8  write data.
- bus_rdata  out  32  read data, zero-extended.
- bus_ready  out  1  access complete.
- tx_start  out  1  pulse to the transmitter.
- tx_data  out  8  byte to send; valid while tx_start is high.
- tx_busy  in  1  transmitter busy.
- rx_ready  in  1  receiver sticky data-ready flag.
- rx_data  in  8  received byte; valid while rx_ready is high.
- rx_clear  out  1  one-cycle pulse that clears rx_ready.

## Operation
- DATA write: pushes bus_wdata[7:0] into the TX FIFO. If the TX FIFO is full, the byte is dropped and tx_drop is set (sticky).
- DATA read: pops the RX FIFO and returns the byte in rdata[7:0]. If the RX FIFO is empty, it returns 0 and the FIFO is unchanged.
- STATUS read layout:
  - bit0 tx_full
  - bit1 rx_nonempty
  - bit2 tx_idle (TX FIFO empty, TX FSM in TX_IDLE, and tx_busy low)
  - bit3 rx_overrun
  - bit4 tx_drop
  - bits 31:5 read as 0.
- STATUS write: wdata[3]=1 clears rx_overrun; wdata[4]=1 clears tx_drop. Other bits are ignored.
- TX FSM states: TX_IDLE, TX_SEND, TX_WAIT.
  - TX_IDLE: if the TX FIFO is non-empty and tx_busy is low, pop the FIFO head into the tx_data register and go to TX_SEND.
  - TX_SEND: tx_start=1 for exactly this cycle; go to TX_WAIT.
  - TX_WAIT: stay until tx_busy is 0, then go to TX_IDLE. The first TX_WAIT cycle always sees busy=1, because the transmitter raises busy the cycle after start.
- RX path:
  - When rx_ready=1 and no clear was issued in the previous cycle: push rx_data into the RX FIFO and drive rx_clear=1 for one cycle.
  - If the RX FIFO is full: the byte is discarded, rx_overrun is set, and rx_clear is still pulsed.
  - The cycle after rx_clear, the controller ignores rx_ready. The receiver's clear takes effect at that edge.
- Simultaneous events in one cycle:
  - A bus DATA read pop together with an RX push: both happen, and the count is unchanged. On a full FIFO, the pop frees space first, so no overrun is raised.
  - A bus DATA write push together with a TX FSM pop: both happen. On a full FIFO, the pop frees space first, so no drop occurs.
  - A STATUS write that clears a sticky flag in the same cycle the flag is set: the set wins.

## Timing
- Values after rst:
  - bus_rdata=0, bus_ready=0.
  - tx_start=0, tx_data=0, rx_clear=0.
  - Both FIFOs empty, both sticky flags 0, TX FSM in TX_IDLE.
- Reset mid-frame: FIFOs and FSM are flushed. The transmitter finishes its current frame on its own. The TX FSM then waits in TX_IDLE until tx_busy=0 before the next start.
- Bus timing:
  - bus_ready is asserted exactly one cycle after bus_en, for both reads and writes.
  - bus_rdata is registered and valid in the bus_ready cycle; it holds its value until the next read completes.
  - A back-to-back bus_en every cycle is legal.
- TX latency: a DATA write in cycle t into an empty FIFO with an idle transmitter gives push at the t edge, pop at t+1, and tx_start=1 in cycle t+2.
- RX latency: rx_ready rising in cycle t gives rx_clear=1 and the push in cycle t. The byte is readable by a DATA read issued in cycle t+1.
- FIFO pointers are log2(DEPTH)+1 bits wide and wrap modulo 2·DEPTH. Full = MSBs differ and the other bits are equal; empty = the pointers are equal.

## Structure
- The shared uart package holds:
  - the register offsets ADDR_DATA=0 and ADDR_STATUS=1;
  - the STATUS bit index constants;
  - the TX FSM state enum.
- One sub-module, uart_fifo (parameterized width and depth, synchronous push/pop, full/empty/count outputs), instantiated twice.

## Test plan
- Reset, then a STATUS read → rdata=0x04 (tx_idle only); tx_start, rx_clear and bus_ready low after reset.
- Write 0x41, then 0x42, to DATA with a transmitter model (busy for 10 cycles after start):
  - tx_start pulses with 0x41 two cycles after the first write;
  - 0x42 is started only after busy falls;
  - exactly one start pulse per byte.
- Write 17 bytes with busy held high and TX_DEPTH=16 → bytes 1–16 are queued, byte 17 is dropped, STATUS bit4=1. Writing 0x10 to STATUS clears it.
- Raise rx_ready with rx_data=0x5A and clear it on rx_clear:
  - rx_clear is one cycle wide;
  - STATUS bit1=1;
  - a DATA read returns 0x5A, after which bit1=0.
- Push 17 RX bytes without reading → STATUS bit3=1 and the first 16 bytes read back in order. A DATA read with the RX FIFO empty returns 0.
- A DATA read in the same cycle an RX byte arrives with the RX FIFO full → no overrun, and the oldest byte is returned.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART controller: register offsets,
// STATUS bit positions and the transmit FSM state encoding.
package uart_pkg;

  localparam logic ADDR_DATA   = 1'b0;
  localparam logic ADDR_STATUS = 1'b1;

  localparam int STAT_TX_FULL    = 0;
  localparam int STAT_RX_NONEMPTY = 1;
  localparam int STAT_TX_IDLE    = 2;
  localparam int STAT_RX_OVERRUN = 3;
  localparam int STAT_TX_DROP    = 4;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_SEND = 2'd1,
    TX_WAIT = 2'd2
  } tx_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with first-word-fall-through head; a pop in the same cycle
// as a push on a full FIFO frees the slot so the push is still accepted.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  import uart_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/uart_mmio.sv
// CPU-facing UART controller: DATA/STATUS registers, TX FIFO feeding the
// transmitter start/busy handshake, RX FIFO drained from the sticky ready flag.
module uart_mmio #(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_en,
  input  logic        bus_we,
  input  logic        bus_addr,
  input  logic [7:0]  bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ready,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  input  logic        rx_ready,
  input  logic [7:0]  rx_data,
  output logic        rx_clear
);
  import uart_pkg::*;

  tx_state_e   state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ready_q, ready_d;
  logic        tx_start_q, tx_start_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        rx_clear_q, rx_clear_d;
  logic        tx_drop_q, tx_drop_d;
  logic        rx_overrun_q, rx_overrun_d;

  logic        tx_push, tx_pop, tx_full, tx_empty;
  logic        rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]  tx_head, rx_head;
  logic [$clog2(TX_DEPTH):0] tx_count;
  logic [$clog2(RX_DEPTH):0] rx_count;
  logic        status_wr;
  logic        tx_idle;
  logic [31:0] status_word;
  logic        unused_counts;

  assign unused_counts = ^{tx_count, rx_count};

  uart_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .wdata(bus_wdata),
    .rdata(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  uart_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .wdata(rx_data),
    .rdata(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  // rx_clear must coincide with the push so the receiver clears at the same edge
  assign rx_clear  = rx_push;
  assign bus_rdata = rdata_q;
  assign bus_ready = ready_q;
  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;

  always_comb begin
    tx_push    = bus_en && bus_we && (bus_addr == ADDR_DATA);
    rx_pop     = bus_en && !bus_we && (bus_addr == ADDR_DATA);
    status_wr  = bus_en && bus_we && (bus_addr == ADDR_STATUS);
    rx_push    = rx_ready && !rx_clear_q && !rst;
    rx_clear_d = rx_push;
    ready_d    = bus_en;
    tx_idle    = tx_empty && (state_q == TX_IDLE) && !tx_busy;

    status_word                   = 32'd0;
    status_word[STAT_TX_FULL]     = tx_full;
    status_word[STAT_RX_NONEMPTY] = !rx_empty;
    status_word[STAT_TX_IDLE]     = tx_idle;
    status_word[STAT_RX_OVERRUN]  = rx_overrun_q;
    status_word[STAT_TX_DROP]     = tx_drop_q;

    rdata_d = rdata_q;
    if (bus_en && !bus_we) begin
      if (bus_addr == ADDR_DATA) begin
        rdata_d = rx_empty ? 32'd0 : {24'd0, rx_head};
      end else begin
        rdata_d = status_word;
      end
    end else begin
      rdata_d = rdata_q;
    end

    state_d    = state_q;
    tx_pop     = 1'b0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    case (state_q)
      TX_IDLE: begin
        if (!tx_empty && !tx_busy) begin
          tx_pop     = 1'b1;
          tx_data_d  = tx_head;
          tx_start_d = 1'b1;
          state_d    = TX_SEND;
        end else begin
          state_d    = TX_IDLE;
        end
      end
      TX_SEND: state_d = TX_WAIT;
      TX_WAIT: begin
        if (!tx_busy) begin
          state_d = TX_IDLE;
        end else begin
          state_d = TX_WAIT;
        end
      end
      default: state_d = TX_IDLE;
    endcase

    // Setting a sticky flag takes priority over a software clear in the same cycle
    if (tx_push && tx_full && !tx_pop) begin
      tx_drop_d = 1'b1;
    end else if (status_wr && bus_wdata[STAT_TX_DROP]) begin
      tx_drop_d = 1'b0;
    end else begin
      tx_drop_d = tx_drop_q;
    end

    if (rx_push && rx_full && !rx_pop) begin
      rx_overrun_d = 1'b1;
    end else if (status_wr && bus_wdata[STAT_RX_OVERRUN]) begin
      rx_overrun_d = 1'b0;
    end else begin
      rx_overrun_d = rx_overrun_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= TX_IDLE;
      rdata_q      <= 32'd0;
      ready_q      <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= 8'd0;
      rx_clear_q   <= 1'b0;
      tx_drop_q    <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rdata_q      <= rdata_d;
      ready_q      <= ready_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      rx_clear_q   <= rx_clear_d;
      tx_drop_q    <= tx_drop_d;
      rx_overrun_q <= rx_overrun_d;
    end
  end

endmodule

// File: tb/tb_uart_mmio.sv
// Self-checking bench for uart_mmio with a transmitter model (busy for 10
// cycles after start) and a sticky-ready receiver driven from the test.
module tb_uart_mmio;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bus_en = 1'b0;
  logic        bus_we = 1'b0;
  logic        bus_addr = 1'b0;
  logic [7:0]  bus_wdata = 8'd0;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        rx_ready = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_clear;

  int checks = 0;
  int failures = 0;
  int n_starts = 0;
  int busy_cnt = 0;
  logic hold_busy = 1'b0;
  logic prev_start = 1'b0;
  logic [7:0] tx_exp_q[$];

  typedef struct {
    logic        we;
    logic        addr;
    logic [7:0]  wd;
    logic        chk;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t init_tab[4];
  logic [7:0] rb_tab[17];

  uart_mmio #(.TX_DEPTH(16), .RX_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .bus_en(bus_en), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .rx_ready(rx_ready), .rx_data(rx_data), .rx_clear(rx_clear)
  );

  always #5 clk = ~clk;

  assign tx_busy = hold_busy || (busy_cnt != 0);

  // Transmitter model: busy rises the cycle after start and lasts 10 cycles
  always @(posedge clk) begin
    if (tx_start) busy_cnt <= 10;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // TX scoreboard: every start pulse must carry the next expected byte
  always @(negedge clk) begin
    if (!rst && tx_start) begin
      n_starts++;
      check("tx_start_while_busy", 32'(tx_busy), 32'd0);
      check("tx_start_width", 32'(prev_start), 32'd0);
      if (tx_exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL tx_unexpected_start: got byte 0x%0h expected no start", tx_data);
      end else begin
        check("tx_byte", 32'(tx_data), 32'(tx_exp_q.pop_front()));
      end
    end
    prev_start <= tx_start;
  end

  task automatic bus_op(input logic we, input logic addr, input logic [7:0] wd,
                        input logic chk, input logic [31:0] exp, input string name);
    @(negedge clk);
    bus_en = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wd;
    @(negedge clk);
    bus_en = 1'b0; bus_we = 1'b0;
    check({name, "_ready"}, 32'(bus_ready), 32'd1);
    if (chk) check(name, bus_rdata, exp);
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    rx_ready = 1'b1; rx_data = b;
    #1 check("rx_clear_on", 32'(rx_clear), 32'd1);
    @(posedge clk);
    #1 rx_ready = 1'b0;
    @(negedge clk);
    check("rx_clear_width", 32'(rx_clear), 32'd0);
  endtask

  task automatic wait_tx_drain(input int budget);
    int n = 0;
    while (tx_exp_q.size() != 0 && n < budget) begin
      @(negedge clk); n++;
    end
    repeat (3) @(negedge clk);
    while (tx_busy && n < budget) begin
      @(negedge clk); n++;
    end
    repeat (3) @(negedge clk);
    check("tx_drain_in_time", 32'(n < budget), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    init_tab[0] = '{1'b0, 1'b1, 8'h00, 1'b1, 32'h04, "rst_status"};
    init_tab[1] = '{1'b0, 1'b0, 8'h00, 1'b1, 32'h00, "empty_data_read"};
    init_tab[2] = '{1'b1, 1'b1, 8'h18, 1'b0, 32'h00, "status_clear_noop"};
    init_tab[3] = '{1'b0, 1'b1, 8'h00, 1'b1, 32'h04, "status_after_clear"};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_bus_ready", 32'(bus_ready), 32'd0);
    check("rst_bus_rdata", bus_rdata, 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_rx_clear", 32'(rx_clear), 32'd0);

    for (int i = 0; i < 4; i++)
      bus_op(init_tab[i].we, init_tab[i].addr, init_tab[i].wd,
             init_tab[i].chk, init_tab[i].exp, init_tab[i].name);

    // TX latency: write in cycle t, start pulse in cycle t+2
    tx_exp_q.push_back(8'h41);
    bus_op(1'b1, 1'b0, 8'h41, 1'b0, 32'd0, "wr_41");
    @(negedge clk);
    check("tx_latency_start", 32'(tx_start), 32'd1);
    check("tx_latency_data", 32'(tx_data), 32'h41);
    tx_exp_q.push_back(8'h42);
    bus_op(1'b1, 1'b0, 8'h42, 1'b0, 32'd0, "wr_42");
    wait_tx_drain(200);
    check("tx_two_starts", n_starts, 32'd2);

    // TX overflow with the transmitter held busy
    hold_busy = 1'b1;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) tx_exp_q.push_back(8'(8'h60 + i));
      bus_op(1'b1, 1'b0, 8'(8'h60 + i), 1'b0, 32'd0, "wr_fill");
    end
    bus_op(1'b0, 1'b1, 8'h00, 1'b1, 32'h11, "status_tx_drop");
    bus_op(1'b1, 1'b1, 8'h10, 1'b0, 32'd0, "clr_tx_drop");
    bus_op(1'b0, 1'b1, 8'h00, 1'b1, 32'h01, "status_drop_cleared");
    @(negedge clk);
    hold_busy = 1'b0;
    wait_tx_drain(1000);
    check("tx_total_starts", n_starts, 32'd18);
    bus_op(1'b0, 1'b1, 8'h00, 1'b1, 32'h04, "status_tx_drained");

    // Single RX byte
    send_rx(8'h5A);
    bus_op(1'b0, 1'b1, 8'h00, 1'b1, 32'h06, "status_rx_nonempty");
    bus_op(1'b0, 1'b0, 8'h00, 1'b1, 32'h5A, "rx_read_5a");
    bus_op(1'b0, 1'b1, 8'h00, 1'b1, 32'h04, "status_rx_empty");

    // RX overrun: 17 bytes, first 16 kept in order
    for (int i = 0; i < 17; i++) begin
      rb_tab[i] = 8'(8'h80 + i);
      send_rx(rb_tab[i]);
    end
    bus_op(1'b0, 1'b1, 8'h00, 1'b1, 32'h0E, "status_rx_overrun");
    for (int i = 0; i < 16; i++)
      bus_op(1'b0, 1'b0, 8'h00, 1'b1, 32'(rb_tab[i]), "rx_overrun_readback");
    bus_op(1'b0, 1'b0, 8'h00, 1'b1, 32'h00, "rx_read_empty");
    bus_op(1'b1, 1'b1, 8'h08, 1'b0, 32'd0, "clr_overrun");
    bus_op(1'b0, 1'b1, 8'h00, 1'b1, 32'h04, "status_overrun_cleared");

    // Read and RX arrival in the same cycle on a full FIFO
    for (int i = 0; i < 16; i++) begin
      rb_tab[i] = 8'(8'h20 + i);
      send_rx(rb_tab[i]);
    end
    rb_tab[16] = 8'h99;
    @(negedge clk);
    bus_en = 1'b1; bus_we = 1'b0; bus_addr = 1'b0;
    rx_ready = 1'b1; rx_data = 8'h99;
    #1 check("simul_rx_clear", 32'(rx_clear), 32'd1);
    @(posedge clk);
    #1 rx_ready = 1'b0;
    @(negedge clk);
    bus_en = 1'b0;
    check("simul_ready", 32'(bus_ready), 32'd1);
    check("simul_oldest", bus_rdata, 32'h20);
    bus_op(1'b0, 1'b1, 8'h00, 1'b1, 32'h06, "status_no_overrun");
    for (int i = 1; i < 17; i++)
      bus_op(1'b0, 1'b0, 8'h00, 1'b1, 32'(rb_tab[i]), "simul_readback");
    bus_op(1'b0, 1'b1, 8'h00, 1'b1, 32'h04, "status_final");
    check("tx_queue_empty", 32'(tx_exp_q.size()), 32'd0);
    check("tx_final_starts", n_starts, 32'd18);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
